weak_aes_inv_core: RTL and testbench
====================================

# weak_aes_inv_core

Iterative decryptor for the 128-bit weak AES-style block cipher used by the encryption core: it undoes the byte-XOR substitution and the linear round-key additions, one round per clock. It sits on the receive side of the crypto path, between the ciphertext source and the plaintext consumer. It uses valid/ready handshakes on both sides and has a separate key-load port that triggers an internal round-key expansion.

## Interface
- NR, 10, number of rounds; must match the encryption side; minimum 1
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- key_load  in  1  single-cycle request to latch `key` and expand round keys; honoured only in IDLE
- key  in  128  cipher key, sampled when `key_load` is honoured
- key_ready  out  1  round keys are valid; reset 0
- in_valid  in  1  ciphertext valid
- in_ready  out  1  core can accept ciphertext; reset 0
- ciphertext  in  128  block to decrypt
- out_valid  out  1  plaintext valid; reset 0
- out_ready  in  1  consumer accepts plaintext
- plaintext  out  128  decrypted block, held stable while `out_valid`; reset 0

## Operation
- Constants:
  - SUB_MASK = {16{8'h55}}.
  - KEY_STEP = 128'h0000_0000_0000_0000_5555_5555_5555_5555.
- Round keys: rk[0] = key; rk[i] = rk[i-1] ^ KEY_STEP for i = 1..NR-1.
- Inverse round r, applied for r = NR-1 down to 0: st = (st ^ rk[r]) ^ SUB_MASK.
- FSM states: IDLE, KEYEXP, ROUND, DONE.
- IDLE:
  - in_ready = key_ready & ~key_load.
  - key_load=1: rk[0] <= key, key_ready <= 0, kidx <= 1, go to KEYEXP.
  - key_load has priority over in_valid in the same cycle; no block is accepted that cycle.
  - in_valid & in_ready: st <= ciphertext, ridx <= NR-1, go to ROUND.
- KEYEXP:
  - One key per cycle: rk[kidx] <= rk[kidx-1] ^ KEY_STEP, kidx++.
  - After rk[NR-1] is written: key_ready <= 1, return to IDLE.
  - key_load is ignored.
- ROUND:
  - One inverse round per cycle using rk[ridx].
  - When ridx == 0: plaintext <= result, out_valid <= 1, go to DONE. Otherwise ridx--.
- DONE:
  - Hold plaintext and out_valid until out_ready=1.
  - On out_ready=1: out_valid <= 0, go to IDLE.
- key_load and in_valid outside IDLE are ignored and not queued; in_ready is 0 outside IDLE.
- Reset mid-operation: all state is discarded; key_ready=0, outputs 0, FSM to IDLE. A new key_load is required before any block is accepted.

## Timing
- Key expansion: key_load honoured at the cycle-T edge; key_ready=1 and in_ready=1 in cycle T+NR (T+10 at default NR).
- Block latency: accepted at the cycle-T edge; ROUND occupies cycles T+1..T+NR; out_valid=1 from cycle T+NR+1.
- Throughput: one block per NR+2 cycles when out_ready is held at 1.
- DONE to IDLE takes one cycle, so in_ready=1 the cycle after the output handshake.
- plaintext changes only on the final-round edge.
- out_valid never drops without a handshake, except on reset.

## Structure
- Shared package `weak_aes_pkg` holds:
  - NR_DEFAULT, SUB_MASK, KEY_STEP
  - the FSM state enum
  - the inv_sub byte function: in ^ 8'h55, its own inverse
- Sub-module `weak_aes_key_sched` contains the round-key register file, the kidx counter and the key_ready flag. It exposes a combinational read port indexed by ridx.
- The top level holds the FSM, the datapath and the handshakes.

## Test plan
- Reset, then key_load with key=0; in_valid with ciphertext=0 -> key_ready rises after 10 cycles; plaintext=128'h0000_0000_0000_0000_5555_5555_5555_5555, 11 cycles after accept.
- key=128'h0011…eeff, ciphertext=128'hFFFF…FFFF -> plaintext=128'hFFFF_FFFF_FFFF_FFFF_AAAA_AAAA_AAAA_AAAA, independent of key. Also cross-check against the encryption core over random plaintext/key pairs.
- Hold out_ready=0 for 5 cycles in DONE -> plaintext and out_valid stable, in_ready=0; a new in_valid is not accepted until after the output handshake.
- key_load and in_valid asserted in the same IDLE cycle -> expansion starts, block not accepted, in_ready=0 for 10 cycles.
- key_load pulsed during ROUND -> ignored; the result matches the old key and key_ready stays 1.
- rst_n low in ROUND cycle 4 -> the next cycle shows out_valid=0, key_ready=0, in_ready=0, plaintext=0; no output appears afterwards.

Source files
------------

// File: rtl/weak_aes_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | weak_aes_pkg: constants, FSM encoding and byte helper shared by  |
// | the weak AES-style cipher cores.            Revision: 1.0        |
// +------------------------------------------------------------------+
package weak_aes_pkg;

    localparam int           NR_DEFAULT = 10;
    localparam logic [127:0] SUB_MASK   = {16{8'h55}};
    localparam logic [127:0] KEY_STEP   = 128'h0000_0000_0000_0000_5555_5555_5555_5555;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_KEYEXP = 2'd1;
    localparam logic [1:0] ST_ROUND  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // The substitution is a plain XOR, so it is its own inverse.
    function automatic logic [7:0] inv_sub(input logic [7:0] b);
        return b ^ 8'h55;
    endfunction

endpackage
`default_nettype wire

// File: rtl/weak_aes_key_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | weak_aes_key_sched: round-key register file, one expansion step  |
// | per cycle, combinational read port.         Revision: 1.0        |
// +------------------------------------------------------------------+
module weak_aes_key_sched
    import weak_aes_pkg::*;
#(
    parameter int NR = NR_DEFAULT,
    parameter int KW = (NR > 1) ? $clog2(NR) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [127:0]  i_key,
    input  logic [KW-1:0] i_ridx,
    output logic [127:0]  o_rk,
    output logic          o_key_ready,
    output logic          o_exp_last
);

    localparam logic [KW-1:0] c_LAST = KW'(NR - 1);

    logic [127:0]  r_rk [NR];
    logic [KW-1:0] r_kidx;
    logic          r_busy;
    logic          r_key_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                r_rk[i] <= '0;
            end
            r_kidx      <= '0;
            r_busy      <= 1'b0;
            r_key_ready <= 1'b0;
        end else if (i_load) begin
            r_rk[0]     <= i_key;
            r_kidx      <= KW'(1);
            // A single-round schedule is complete as soon as rk[0] lands.
            r_busy      <= (NR > 1);
            r_key_ready <= (NR == 1);
        end else if (r_busy) begin
            r_rk[r_kidx] <= r_rk[r_kidx - 1'b1] ^ KEY_STEP;
            if (r_kidx == c_LAST) begin
                r_busy      <= 1'b0;
                r_key_ready <= 1'b1;
            end else begin
                r_kidx <= r_kidx + 1'b1;
            end
        end
    end

    assign o_rk        = r_rk[i_ridx];
    assign o_key_ready = r_key_ready;
    assign o_exp_last  = r_busy & (r_kidx == c_LAST);

endmodule
`default_nettype wire

// File: rtl/weak_aes_inv_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | weak_aes_inv_core: iterative one-round-per-cycle decryptor with  |
// | valid/ready ports and on-chip key expansion. Revision: 1.0       |
// +------------------------------------------------------------------+
module weak_aes_inv_core
    import weak_aes_pkg::*;
#(
    parameter int NR = NR_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key,
    output logic         key_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);

    localparam int            KW     = (NR > 1) ? $clog2(NR) : 1;
    localparam logic [KW-1:0] c_LAST = KW'(NR - 1);

    logic [1:0]    r_state;
    logic [127:0]  r_st;
    logic [KW-1:0] r_ridx;
    logic [127:0]  r_pt;
    logic          r_out_valid;

    logic          w_load;
    logic [127:0]  w_rk;
    logic          w_exp_last;
    logic [127:0]  w_mix;
    logic [127:0]  w_round;

    assign w_load = key_load & (r_state == ST_IDLE);

    weak_aes_key_sched #(
        .NR (NR),
        .KW (KW)
    ) u_key_sched (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_key       (key),
        .i_ridx      (r_ridx),
        .o_rk        (w_rk),
        .o_key_ready (key_ready),
        .o_exp_last  (w_exp_last)
    );

    assign w_mix = r_st ^ w_rk;

    for (genvar g = 0; g < 16; g++) begin : g_bytes
        assign w_round[8*g +: 8] = inv_sub(w_mix[8*g +: 8]);
    end

    // key_load wins over in_valid, so a same-cycle block is refused.
    assign in_ready = (r_state == ST_IDLE) & key_ready & ~key_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_st        <= '0;
            r_ridx      <= '0;
            r_pt        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (key_load) begin
                        r_state <= (NR > 1) ? ST_KEYEXP : ST_IDLE;
                    end else if (in_valid && in_ready) begin
                        r_st    <= ciphertext;
                        r_ridx  <= c_LAST;
                        r_state <= ST_ROUND;
                    end
                end
                ST_KEYEXP: begin
                    if (w_exp_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ROUND: begin
                    r_st <= w_round;
                    if (r_ridx == '0) begin
                        r_pt        <= w_round;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_ridx <= r_ridx - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign plaintext = r_pt;

endmodule
`default_nettype wire

// File: tb/tb_weak_aes_inv_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_weak_aes_inv_core: directed self-checking bench for the       |
// | weak AES-style decryptor.                   Revision: 1.0        |
// +------------------------------------------------------------------+
module tb_weak_aes_inv_core;

    localparam int           NR   = 10;
    localparam logic [127:0] SUB  = {16{8'h55}};
    localparam logic [127:0] STEP = 128'h0000_0000_0000_0000_5555_5555_5555_5555;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_load;
    logic [127:0] key;
    logic         key_ready;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    weak_aes_inv_core #(.NR(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_load   (key_load),
        .key        (key),
        .key_ready  (key_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    always #5 clk = ~clk;

    // Forward cipher: the decryptor must undo exactly this.
    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] st = pt;
        logic [127:0] rk = k;
        for (int r = 0; r < NR; r++) begin
            st = (st ^ SUB) ^ rk;
            rk = rk ^ STEP;
        end
        return st;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_key(input logic [127:0] k, output int n);
        key      = k;
        key_load = 1'b1;
        tick;
        key_load = 1'b0;
        n = 0;
        while (!key_ready && n < 50) begin
            tick;
            n++;
        end
    endtask

    task automatic wait_in_ready(output int n);
        n = 0;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick;
            n++;
        end
    endtask

    task automatic send(input logic [127:0] ct, output int lat);
        int w;
        ciphertext = ct;
        in_valid   = 1'b1;
        wait_in_ready(w);
        tick;
        in_valid = 1'b0;
        wait_out(lat);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        n_checks += 4;
        if (key_ready !== 1'b0) begin n_fail++; $display("FAIL reset_key_ready: got %b expected 0", key_ready); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (plaintext !== 128'h0) begin n_fail++; $display("FAIL reset_plaintext: got %h expected 0", plaintext); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_zero_key;
        int n;
        int lat;
        load_key(128'h0, n);
        n_checks += 2;
        if (n !== NR - 1) begin n_fail++; $display("FAIL zero_key_exp_cycles: got %0d expected %0d", n, NR - 1); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_key_in_ready: got %b expected 1", in_ready); end
        send(128'h0, lat);
        n_checks += 3;
        if (lat !== NR) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, NR); end
        if (plaintext !== 128'h0000_0000_0000_0000_5555_5555_5555_5555) begin
            n_fail++; $display("FAIL zero_plaintext: got %h expected 00000000000000005555555555555555", plaintext);
        end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_done_in_ready: got %b expected 0", in_ready); end
        tick;
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_handshake_out_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_after_hs_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_key_independent;
        int n;
        int lat;
        load_key(128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, n);
        send({128{1'b1}}, lat);
        n_checks += 2;
        if (lat !== NR) begin n_fail++; $display("FAIL keyind_latency: got %0d expected %0d", lat, NR); end
        if (plaintext !== 128'hFFFF_FFFF_FFFF_FFFF_AAAA_AAAA_AAAA_AAAA) begin
            n_fail++; $display("FAIL keyind_plaintext: got %h expected FFFFFFFFFFFFFFFFAAAAAAAAAAAAAAAA", plaintext);
        end
        tick;
    endtask

    task automatic test_backpressure;
        int lat;
        logic [127:0] k  = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
        logic [127:0] p1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        logic [127:0] p2 = 128'hdead_beef_cafe_f00d_1234_5678_9abc_def0;
        out_ready = 1'b0;
        send(enc(p1, k), lat);
        ciphertext = enc(p2, k);
        in_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_checks += 3;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
            if (plaintext !== p1) begin n_fail++; $display("FAIL bp_plaintext[%0d]: got %h expected %h", i, plaintext, p1); end
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
        end
        out_ready = 1'b1;
        tick;
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_hs_out_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_hs_in_ready: got %b expected 1", in_ready); end
        tick;
        in_valid = 1'b0;
        wait_out(lat);
        n_checks += 2;
        if (lat !== NR) begin n_fail++; $display("FAIL bp_second_latency: got %0d expected %0d", lat, NR); end
        if (plaintext !== p2) begin n_fail++; $display("FAIL bp_second_plaintext: got %h expected %h", plaintext, p2); end
        tick;
    endtask

    task automatic test_load_priority;
        int n;
        int bad;
        int lat;
        logic [127:0] k2 = 128'h1357_9bdf_2468_ace0_0f1e_2d3c_4b5a_6978;
        logic [127:0] p  = 128'h8000_0000_0000_0001_7fff_ffff_ffff_fffe;
        key        = k2;
        key_load   = 1'b1;
        ciphertext = enc(p, k2);
        in_valid   = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL prio_in_ready_same_cycle: got %b expected 0", in_ready); end
        tick;
        key_load = 1'b0;
        n   = 0;
        bad = 0;
        while (!key_ready && n < 50) begin
            if (in_ready || out_valid) bad++;
            tick;
            n++;
        end
        n_checks += 2;
        if (n !== NR - 1) begin n_fail++; $display("FAIL prio_exp_cycles: got %0d expected %0d", n, NR - 1); end
        if (bad !== 0) begin n_fail++; $display("FAIL prio_busy_cycles: got %0d expected 0", bad); end
        tick;
        in_valid = 1'b0;
        wait_out(lat);
        n_checks += 2;
        if (lat !== NR) begin n_fail++; $display("FAIL prio_latency: got %0d expected %0d", lat, NR); end
        if (plaintext !== p) begin n_fail++; $display("FAIL prio_plaintext: got %h expected %h", plaintext, p); end
        tick;
    endtask

    task automatic test_load_during_round;
        int w;
        int lat;
        logic [127:0] k2 = 128'h1357_9bdf_2468_ace0_0f1e_2d3c_4b5a_6978;
        logic [127:0] p  = 128'h0f0f_0f0f_f0f0_f0f0_3c3c_3c3c_c3c3_c3c3;
        ciphertext = enc(p, k2);
        in_valid   = 1'b1;
        wait_in_ready(w);
        tick;
        in_valid = 1'b0;
        tick;
        key      = 128'hffee_ddcc_bbaa_9988_7766_5544_3322_1100;
        key_load = 1'b1;
        tick;
        key_load = 1'b0;
        n_checks++;
        if (key_ready !== 1'b1) begin n_fail++; $display("FAIL ldround_key_ready: got %b expected 1", key_ready); end
        wait_out(lat);
        n_checks += 2;
        if (lat !== NR - 2) begin n_fail++; $display("FAIL ldround_latency: got %0d expected %0d", lat, NR - 2); end
        if (plaintext !== p) begin n_fail++; $display("FAIL ldround_plaintext: got %h expected %h", plaintext, p); end
        tick;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ldround_in_ready_after: got %b expected 1", in_ready); end
    endtask

    task automatic test_back_to_back;
        int w;
        int lat;
        int t_acc [3];
        logic [127:0] k2 = 128'h1357_9bdf_2468_ace0_0f1e_2d3c_4b5a_6978;
        logic [127:0] p  [3];
        p[0] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        p[1] = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
        p[2] = 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ciphertext = enc(p[i], k2);
            wait_in_ready(w);
            t_acc[i] = cyc;
            tick;
            wait_out(lat);
            n_checks++;
            if (plaintext !== p[i]) begin n_fail++; $display("FAIL b2b_plaintext[%0d]: got %h expected %h", i, plaintext, p[i]); end
            tick;
        end
        in_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (t_acc[i] - t_acc[i-1] !== NR + 2) begin
                n_fail++; $display("FAIL b2b_interval[%0d]: got %0d expected %0d", i, t_acc[i] - t_acc[i-1], NR + 2);
            end
        end
    endtask

    task automatic test_random;
        int n;
        int lat;
        logic [127:0] k;
        logic [127:0] p;
        for (int i = 0; i < 4; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
            load_key(k, n);
            send(enc(p, k), lat);
            n_checks++;
            if (plaintext !== p) begin n_fail++; $display("FAIL rand_plaintext[%0d]: got %h expected %h", i, plaintext, p); end
            tick;
        end
    endtask

    task automatic test_reset_mid_round;
        int w;
        int bad;
        ciphertext = 128'h5a5a_5a5a_a5a5_a5a5_1234_5678_9abc_def0;
        in_valid   = 1'b1;
        wait_in_ready(w);
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        if (key_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_key_ready: got %b expected 0", key_ready); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
        if (plaintext !== 128'h0) begin n_fail++; $display("FAIL midrst_plaintext: got %h expected 0", plaintext); end
        rst_n    = 1'b1;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (out_valid || in_ready) bad++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL midrst_quiet_cycles: got %0d expected 0", bad); end
    endtask

    initial begin
        rst_n      = 1'b0;
        key_load   = 1'b0;
        key        = '0;
        in_valid   = 1'b0;
        ciphertext = '0;
        out_ready  = 1'b1;
        test_reset;
        test_zero_key;
        test_key_independent;
        test_backpressure;
        test_load_priority;
        test_load_during_round;
        test_back_to_back;
        test_random;
        test_reset_mid_round;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
